// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bundle for seq_chunk_adder.
// The master side issues operations and the slave side computes them.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

  modport master (
    output start, in1, in2, cin, sub,
    input  busy, done, out, cout, ovf
  );

  modport slave (
    input  start, in1, in2, cin, sub,
    output busy, done, out, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that sums CHUNK bits per cycle through a ripple slice.
// The result, carry and overflow are published together on the last chunk.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic          clk,
  input logic          rst,
  seq_chunk_adder_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] out_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             cy;
  logic             cy_msb;

  assign last = (idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk select and ripple-carry slice; cy_msb is the carry into the top bit
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int j = 0; j < N; j++) begin
      if (idx == IDX_W'(j)) begin
        a_slice = a_reg[j*CHUNK +: CHUNK];
        b_slice = b_reg[j*CHUNK +: CHUNK];
      end
    end
    cy      = carry;
    cy_msb  = carry;
    s_slice = '0;
    for (int k = 0; k < CHUNK; k++) begin
      cy_msb     = cy;
      s_slice[k] = a_slice[k] ^ b_slice[k] ^ cy;
      cy         = (a_slice[k] & b_slice[k]) | (cy & (a_slice[k] ^ b_slice[k]));
    end
    acc_nxt = acc_reg;
    for (int j = 0; j < N; j++) begin
      if (idx == IDX_W'(j)) acc_nxt[j*CHUNK +: CHUNK] = s_slice;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      out_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= bus.sub ? 1'b1 : bus.cin;
    end else if (state == RUN) begin
      idx   <= idx + 1'b1;
      carry <= cy;
      if (last) begin
        out_reg  <= acc_nxt;
        cout_reg <= cy;
        ovf_reg  <= cy ^ cy_msb;
      end
    end
  end

  // Operand and partial-sum storage; every chunk is overwritten before use
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= bus.in1;
      b_reg <= bus.sub ? ~bus.in2 : bus.in2;
    end else if (state == RUN) begin
      acc_reg <= acc_nxt;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder (WIDTH=16, CHUNK=4): vector table plus corner sequences,
// with results checked by a scoreboard on every done pulse.
module tb_seq_chunk_adder;
  localparam int WIDTH = 16;
  localparam int CHUNK = 4;

  typedef struct {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_cnt;
  int   cyc;
  int   done_cyc[$];
  exp_t sb[$];
  vec_t vecs[10];

  seq_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    exp_t        r;
    logic [16:0] t;
    if (s) t = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else   t = {1'b0, a} + {1'b0, b} + {16'd0, c};
    r.out  = t[15:0];
    r.cout = t[16];
    if (s) r.ovf = (a[15] != b[15]) && (t[15] != a[15]);
    else   r.ovf = (a[15] == b[15]) && (t[15] != a[15]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      done_cnt++;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out",  {16'd0, bus.out}, {16'd0, e.out});
        check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
        check("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
      end
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = c;
    bus.sub = s;
  endtask

  // lat counts edges from the accept edge to the edge that samples done
  task automatic run_op(input vec_t v, output int lat, output int busy_n);
    @(negedge clk);
    bus.start = 1'b1;
    drive(v.a, v.b, v.cin, v.sub);
    sb.push_back(v.e);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!bus.done && lat < 50) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  initial begin
    int   lat;
    int   busy_n;
    int   d0;
    vec_t v;

    total = 0; bad = 0; done_cnt = 0; cyc = 0;
    bus.start = 1'b0;
    drive(16'h0, 16'h0, 1'b0, 1'b0);

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[2] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, '{16'h2144, 1'b0, 1'b0}};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[6] = '{16'h1234, 16'h1234, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vecs[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};

    // Reset state
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_out",  {16'd0, bus.out},  32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf},  32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], lat, busy_n);
      if (i == 0) begin
        check("latency_edges", lat, 32'd5);
        check("busy_cycles",   busy_n, 32'd4);
      end
    end

    // Result holds while idle
    repeat (6) @(negedge clk);
    check("hold_out", {16'd0, bus.out}, 32'h8000);
    check("hold_ovf", {31'd0, bus.ovf}, 32'd1);

    // Start and operand changes during RUN are ignored
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (8) @(negedge clk);
    check("ignore_done_count", done_cnt - d0, 32'd1);

    // Reset aborts a RUN in progress
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_in_run", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_out",  {16'd0, bus.out},  32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);

    // Back-to-back: start held through the DONE cycle
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    drive(16'h0102, 16'h0304, 1'b0, 1'b0);
    sb.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
    @(negedge clk);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1);
    sb.push_back(model(16'h8000, 16'h0001, 1'b0, 1'b1));
    wait_done();
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 32'd2);
    if (done_cyc.size() >= 2)
      check("b2b_spacing", done_cyc[$] - done_cyc[$-1], 32'd5);
    else
      check("b2b_spacing", 32'd0, 32'd5);

    // Random mixed operations against the model
    for (int i = 0; i < 8; i++) begin
      v.a   = 16'($urandom);
      v.b   = 16'($urandom);
      v.cin = 1'($urandom);
      v.sub = 1'($urandom);
      v.e   = model(v.a, v.b, v.cin, v.sub);
      run_op(v, lat, busy_n);
      check("rand_latency", lat, 32'd5);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, bits summed per cycle by an internal CHUNK-bit ripple-carry slice; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port in1, input, WIDTH, operand A.
REQ-007 The block SHALL have port in2, input, WIDTH, operand B.
REQ-008 The block SHALL have port cin, input, 1, carry-in for add mode.
REQ-009 The block SHALL have port sub, input, 1, 0 = A+B+cin, 1 = A-B.
REQ-010 The block SHALL have port busy, output, 1, high while in RUN.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port out, output, WIDTH, result.
REQ-013 The block SHALL have port cout, output, 1, carry out of bit WIDTH-1 (add); for sub, 1 = no borrow.
REQ-014 The block SHALL have port ovf, output, 1, two's-complement overflow.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 Accept: in IDLE or DONE with start=1 at an edge, the block SHALL capture in1, in2 (inverted when sub=1), the effective carry-in (cin if sub=0, 1 if sub=1), and reset the chunk index to 0, then go to RUN.
REQ-017 Inputs in1/in2/cin/sub SHALL be sampled only at accept; changes during RUN SHALL have no effect.
REQ-018 RUN: each edge, the block SHALL add chunk i of A and B plus the carry register, write the CHUNK-bit sum into result bits [i*CHUNK +: CHUNK], update the carry register, and increment i.
REQ-019 On the edge processing chunk N-1, the block SHALL go to DONE and update out, cout, and ovf (ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1).
REQ-020 Latency: with accept at edge k, done SHALL be high in the cycle following edge k+N (exactly one cycle), and busy SHALL be high for exactly N cycles.
REQ-021 DONE SHALL last one cycle, then return to IDLE, or go to RUN if start=1 (back-to-back, no bubble).
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 out, cout, and ovf SHALL hold their last completed values until the next completion; partial results SHALL NOT be visible on out during RUN.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-025 For N=1 (CHUNK=WIDTH), done SHALL follow accept by one edge, still via RUN for one cycle.

Reset
REQ-026 While rst=1 at an edge, the block SHALL go to IDLE and clear out, cout, ovf, the carry register, and the chunk index to 0; busy and done SHALL be 0.
REQ-027 rst SHALL take priority over start and abort any RUN in progress; no done pulse SHALL follow an aborted operation.

Verification (WIDTH=16, CHUNK=4)
REQ-028 The bench SHALL cover: add 0xFFFF+0x0001, cin=0 -> out=0x0000, cout=1, ovf=0; done exactly 5 edges after accept edge; busy high 4 cycles.
REQ-029 The bench SHALL cover: add 0x7FFF+0x0001, cin=0 -> out=0x8000, cout=0, ovf=1; add 0x1234+0x0F0F, cin=1 -> out=0x2144, cout=0, ovf=0.
REQ-030 The bench SHALL cover: sub 0x0005-0x0007 -> out=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> out=0x7FFF, cout=1, ovf=1.
REQ-031 The bench SHALL cover: start pulsed again and in1 changed during RUN -> ignored; result matches the originally captured operands; single done pulse.
REQ-032 The bench SHALL cover: rst asserted at RUN cycle 2 -> next cycle busy=0, done=0, out=0x0000; no done pulse afterwards until a new start.
REQ-033 The bench SHALL cover: start held high in the DONE cycle with new operands -> second RUN begins immediately; two done pulses 5 cycles apart, each with the correct result.
